// File: rtl/vga_board_gen.sv
// VGA timing plus board renderer in one two-stage registered pipeline.
// Stage 1 samples the counter state and cell tracking into pixel attributes.
// Stage 2 resolves colour and drives the pins.
// All outputs are mutually aligned and lag the counter state by two clocks.
// Button actions are synchronised, latched as pending flags, and applied only
// on the last cycle of a frame, so a frame is never drawn half-updated.
module vga_board_gen #(
    parameter int HACTIVE  = 640,
    parameter int HFP      = 16,
    parameter int HSYN     = 96,
    parameter int HBP      = 48,
    parameter int VACTIVE  = 480,
    parameter int VFP      = 10,
    parameter int VSYN     = 2,
    parameter int VBP      = 33,
    parameter int SYNC_POL = 0,
    parameter int COLS     = 8,
    parameter int ROWS     = 8,
    parameter int CELL_W   = 64,
    parameter int CELL_H   = 48,
    parameter int ORG_X    = 64,
    parameter int ORG_Y    = 48,
    parameter int LINE_W   = 2,
    parameter int CW       = 8
) (
    input  logic                    vgaclk,
    input  logic                    rst_n,
    input  logic                    btn_right,
    input  logic                    btn_down,
    input  logic                    btn_select,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    sync_b,
    output logic                    blank_b,
    output logic [CW-1:0]           red,
    output logic [CW-1:0]           green,
    output logic [CW-1:0]           blue,
    output logic [$clog2(COLS)-1:0] cur_col,
    output logic [$clog2(ROWS)-1:0] cur_row,
    output logic                    frame_start
);
    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;
    localparam int HW   = $clog2(HMAX);
    localparam int VW   = $clog2(VMAX);
    localparam int CCW  = $clog2(COLS);
    localparam int CRW  = $clog2(ROWS);
    localparam int XW   = $clog2(CELL_W);
    localparam int YW   = $clog2(CELL_H);

    localparam logic [HW-1:0]  H_LAST = HW'(HMAX - 1);
    localparam logic [VW-1:0]  V_LAST = VW'(VMAX - 1);
    localparam logic [HW-1:0]  H_ACT  = HW'(HACTIVE);
    localparam logic [VW-1:0]  V_ACT  = VW'(VACTIVE);
    localparam logic [HW-1:0]  H_SS   = HW'(HACTIVE + HFP);
    localparam logic [HW-1:0]  H_SE   = HW'(HACTIVE + HFP + HSYN);
    localparam logic [VW-1:0]  V_SS   = VW'(VACTIVE + VFP);
    localparam logic [VW-1:0]  V_SE   = VW'(VACTIVE + VFP + VSYN);
    localparam logic [HW-1:0]  H_ORG  = HW'(ORG_X);
    localparam logic [VW-1:0]  V_ORG  = VW'(ORG_Y);
    localparam logic [XW-1:0]  X_LAST = XW'(CELL_W - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(CELL_H - 1);
    localparam logic [XW-1:0]  X_LO   = XW'(LINE_W);
    localparam logic [XW-1:0]  X_HI   = XW'(CELL_W - LINE_W);
    localparam logic [YW-1:0]  Y_LO   = YW'(LINE_W);
    localparam logic [YW-1:0]  Y_HI   = YW'(CELL_H - LINE_W);
    localparam logic [CCW-1:0] C_LAST = CCW'(COLS - 1);
    localparam logic [CRW-1:0] R_LAST = CRW'(ROWS - 1);
    localparam logic           POL    = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam logic           IN_X0  = (ORG_X == 0) ? 1'b1 : 1'b0;
    localparam logic           IN_Y0  = (ORG_Y == 0) ? 1'b1 : 1'b0;

    // Fill colour: 2'b10 repeated across the channel, MSB first.
    function automatic logic [CW-1:0] grey_fill();
        logic [CW-1:0] v;
        for (int i = 0; i < CW; i++) begin
            v[i] = 1'((i & 1) != 0);
        end
        return v;
    endfunction

    localparam logic [CW-1:0] GREY = grey_fill();

    logic [HW-1:0]              r_hcnt, w_h_next;
    logic [VW-1:0]              r_vcnt, w_v_next;
    logic                       w_h_wrap, w_v_wrap, w_frame_end;
    logic                       r_in_x, w_in_x_n, r_in_y, w_in_y_n;
    logic [XW-1:0]              r_x_off, w_x_off_n;
    logic [YW-1:0]              r_y_off, w_y_off_n;
    logic [CCW-1:0]             r_col, w_col_n, r_cur_col;
    logic [CRW-1:0]             r_row, w_row_n, r_cur_row;
    logic [ROWS-1:0][COLS-1:0]  r_mark;
    logic [2:0]                 r_sync1, r_sync2, r_prev, r_pend, w_edge;
    logic                       r_s1_vis, r_s1_board, r_s1_grid, r_s1_cursor;
    logic                       r_s1_mark, r_s1_hs, r_s1_vs, r_s1_fs;
    logic                       r_hsync, r_vsync, r_sync_b, r_blank_b, r_fs;
    logic [CW-1:0]              r_red, r_green, r_blue, w_red, w_green, w_blue;

    assign w_h_wrap    = (r_hcnt == H_LAST);
    assign w_v_wrap    = (r_vcnt == V_LAST);
    assign w_frame_end = w_h_wrap & w_v_wrap;
    assign w_edge      = r_sync2 & ~r_prev;

    // Next raster position: hcnt wraps every line, vcnt steps on each hcnt wrap.
    always_comb begin
        w_h_next = r_hcnt + HW'(1);
        w_v_next = r_vcnt;
        if (w_h_wrap) begin
            w_h_next = '0;
            if (w_v_wrap) begin
                w_v_next = '0;
            end else begin
                w_v_next = r_vcnt + VW'(1);
            end
        end else begin
            w_h_next = r_hcnt + HW'(1);
        end
    end

    // Incremental cell tracking for the next position, no divide needed.
    always_comb begin
        w_in_x_n  = r_in_x;
        w_x_off_n = r_x_off;
        w_col_n   = r_col;
        w_in_y_n  = r_in_y;
        w_y_off_n = r_y_off;
        w_row_n   = r_row;
        if (w_h_next == H_ORG) begin
            w_in_x_n  = 1'b1;
            w_x_off_n = '0;
            w_col_n   = '0;
        end else if (r_in_x) begin
            if (r_x_off == X_LAST) begin
                w_x_off_n = '0;
                if (r_col == C_LAST) begin
                    w_in_x_n = 1'b0;
                end else begin
                    w_col_n = r_col + CCW'(1);
                end
            end else begin
                w_x_off_n = r_x_off + XW'(1);
            end
        end else begin
            w_in_x_n = 1'b0;
        end
        if (!w_h_wrap) begin
            w_in_y_n = r_in_y;
        end else if (w_v_next == V_ORG) begin
            w_in_y_n  = 1'b1;
            w_y_off_n = '0;
            w_row_n   = '0;
        end else if (r_in_y) begin
            if (r_y_off == Y_LAST) begin
                w_y_off_n = '0;
                if (r_row == R_LAST) begin
                    w_in_y_n = 1'b0;
                end else begin
                    w_row_n = r_row + CRW'(1);
                end
            end else begin
                w_y_off_n = r_y_off + YW'(1);
            end
        end else begin
            w_in_y_n = 1'b0;
        end
    end

    // Raster counters and the cell tracking that stays aligned with them.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt  <= '0;
            r_vcnt  <= '0;
            r_in_x  <= IN_X0;
            r_x_off <= '0;
            r_col   <= '0;
            r_in_y  <= IN_Y0;
            r_y_off <= '0;
            r_row   <= '0;
        end else begin
            r_hcnt  <= w_h_next;
            r_vcnt  <= w_v_next;
            r_in_x  <= w_in_x_n;
            r_x_off <= w_x_off_n;
            r_col   <= w_col_n;
            r_in_y  <= w_in_y_n;
            r_y_off <= w_y_off_n;
            r_row   <= w_row_n;
        end
    end

    // Button synchronisers, pending flags, and the frame-boundary update.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 3'b000;
            r_sync2   <= 3'b000;
            r_prev    <= 3'b000;
            r_pend    <= 3'b000;
            r_cur_col <= '0;
            r_cur_row <= '0;
            r_mark    <= '0;
        end else begin
            r_sync1 <= {btn_select, btn_down, btn_right};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_frame_end) begin
                // An edge seen on this very cycle is carried into the next frame.
                r_pend <= w_edge;
                if (r_pend[2]) begin
                    r_mark[r_cur_row][r_cur_col] <= ~r_mark[r_cur_row][r_cur_col];
                end
                if (r_pend[0]) begin
                    r_cur_col <= (r_cur_col == C_LAST) ? '0 : r_cur_col + CCW'(1);
                end
                if (r_pend[1]) begin
                    r_cur_row <= (r_cur_row == R_LAST) ? '0 : r_cur_row + CRW'(1);
                end
            end else begin
                r_pend <= r_pend | w_edge;
            end
        end
    end

    // Stage 1: reduce counter state to per-pixel attributes.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vis    <= 1'b0;
            r_s1_board  <= 1'b0;
            r_s1_grid   <= 1'b0;
            r_s1_cursor <= 1'b0;
            r_s1_mark   <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_fs     <= 1'b0;
        end else begin
            r_s1_vis    <= (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
            r_s1_board  <= r_in_x && r_in_y;
            r_s1_grid   <= (r_x_off < X_LO) || (r_x_off >= X_HI) ||
                           (r_y_off < Y_LO) || (r_y_off >= Y_HI);
            r_s1_cursor <= (r_col == r_cur_col) && (r_row == r_cur_row);
            r_s1_mark   <= r_mark[r_row][r_col];
            r_s1_hs     <= (r_hcnt >= H_SS) && (r_hcnt < H_SE);
            r_s1_vs     <= (r_vcnt >= V_SS) && (r_vcnt < V_SE);
            r_s1_fs     <= (r_hcnt == '0) && (r_vcnt == '0);
        end
    end

    // Colour priority: blank, off-board, grid line, cursor, mark, fill.
    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (!r_s1_vis) begin
            w_red = '0;
        end else if (!r_s1_board) begin
            w_red   = '1;
            w_green = '1;
            w_blue  = '1;
        end else if (r_s1_grid) begin
            w_red = '0;
        end else if (r_s1_cursor) begin
            w_red = '1;
        end else if (r_s1_mark) begin
            w_red = '0;
        end else begin
            w_red   = GREY;
            w_green = GREY;
            w_blue  = GREY;
        end
    end

    // Stage 2: registered pin drivers.
    always_ff @(posedge vgaclk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync   <= ~POL;
            r_vsync   <= ~POL;
            r_sync_b  <= 1'b1;
            r_blank_b <= 1'b0;
            r_red     <= '0;
            r_green   <= '0;
            r_blue    <= '0;
            r_fs      <= 1'b0;
        end else begin
            r_hsync   <= r_s1_hs ? POL : ~POL;
            r_vsync   <= r_s1_vs ? POL : ~POL;
            r_sync_b  <= ~(r_s1_hs | r_s1_vs);
            r_blank_b <= r_s1_vis;
            r_red     <= w_red;
            r_green   <= w_green;
            r_blue    <= w_blue;
            r_fs      <= r_s1_fs;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign sync_b      = r_sync_b;
    assign blank_b     = r_blank_b;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign cur_col     = r_cur_col;
    assign cur_row     = r_cur_row;
    assign frame_start = r_fs;
endmodule
